// File: rtl/game_pkg.sv
// Shared types and constants for the game screen sequencer: screen states, powerup codes
// and the powerup LFSR.
package game_pkg;

   typedef enum logic [2:0] {
      StLogo,
      StGetReady,
      StPlay,
      StTimesUp,
      StLeader
   } screen_e;

   localparam logic [1:0] PuSnitch     = 2'd0;
   localparam logic [1:0] PuTimeTurner = 2'd1;
   localparam logic [1:0] PuLightning  = 2'd2;
   localparam logic [1:0] PuBroom      = 2'd3;

   localparam logic [3:0] LfsrSeed = 4'b1001;

   // x^4 + x^3 + 1, shifting towards the MSB.
   function automatic logic [3:0] lfsr_next(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

   // One-hot powerup flags {broom, lightning, time_turner, snitch}.
   function automatic logic [3:0] pu_onehot(input logic [1:0] code, input logic two_player);
      logic [1:0] sel;
      sel = (two_player && (code == PuSnitch)) ? PuBroom : code;
      return 4'b0001 << sel;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame and second tick generator: detects the falling edge of registered vertical sync and
// divides frames down to game seconds.
module frame_timer #(
   parameter int unsigned FRAMES_PER_SEC = 60
) (
   input  logic iVGA_CLK,
   input  logic iRST_n,
   input  logic vs_i,
   input  logic clear_i,
   output logic frame_tick_o,
   output logic sec_tick_o
);

   localparam int unsigned CntW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

   logic            vs_q, vs_qq;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign frame_tick_o = vs_qq & ~vs_q;
   assign sec_tick_o   = frame_tick_o && (cnt_q == CntW'(FRAMES_PER_SEC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || sec_tick_o) begin
         cnt_d = '0;
      end else if (frame_tick_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Sync history resets low so a high iVS at reset release is not seen as an edge.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vs_q  <= 1'b0;
         vs_qq <= 1'b0;
         cnt_q <= '0;
      end else begin
         vs_q  <= vs_i;
         vs_qq <= vs_q;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_screen_sequencer.sv
// Game screen sequencer: LOGO -> GET_READY -> PLAY -> TIMES_UP -> LEADER, paced by frame ticks.
// Define GAME_SCREEN_POWERUP_EN to build the LFSR-driven powerup scheduler.
module game_screen_sequencer
   import game_pkg::*;
#(
   parameter int unsigned FRAMES_PER_SEC  = 60,
   parameter int unsigned READY_SEC       = 3,
   parameter int unsigned PLAY_SEC        = 60,
   parameter int unsigned TIMES_UP_SEC    = 3,
   parameter int unsigned LEADER_SEC      = 10,
   parameter int unsigned PU_PERIOD_SEC   = 10,
   parameter int unsigned PU_DURATION_SEC = 5
) (
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic       iVS,
   input  logic       start_btn,
   input  logic       two_player_sel,
   input  logic       house_valid,
   output logic       logo,
   output logic       get_ready,
   output logic       play,
   output logic       times_up,
   output logic       leaderboard,
   output logic       two_player_mode,
   output logic       snitch_powerup,
   output logic       time_turner_powerup,
   output logic       lightning_powerup,
   output logic       broom_powerup,
   output logic [6:0] time_left
);

   if (PLAY_SEC == 0 || PLAY_SEC > 127) begin : g_bad_play_sec
      $error("PLAY_SEC must be in 1..127");
   end
   if (PU_DURATION_SEC >= PU_PERIOD_SEC) begin : g_bad_pu_timing
      $error("PU_DURATION_SEC must be less than PU_PERIOD_SEC");
   end

   screen_e     state_q, state_d;
   logic        state_chg;
   logic        frame_tick, sec_tick;
   logic        start_q, start_edge;
   logic        start_pend_q, start_pend_d;
   logic        two_d;
   logic [6:0]  tl_q, tl_d;
   logic [15:0] sec_cnt_q, sec_cnt_d;

   frame_timer #(
      .FRAMES_PER_SEC(FRAMES_PER_SEC)
   ) u_frame_timer (
      .iVGA_CLK    (iVGA_CLK),
      .iRST_n      (iRST_n),
      .vs_i        (iVS),
      .clear_i     (state_chg),
      .frame_tick_o(frame_tick),
      .sec_tick_o  (sec_tick)
   );

   assign start_edge = start_btn & ~start_q;
   assign state_chg  = (state_d != state_q);
   assign time_left  = tl_q;

   always_comb begin
      state_d = state_q;
      if (frame_tick) begin
         case (state_q)
            StLogo:     if (start_pend_q && house_valid) state_d = StGetReady;
            StGetReady: if (sec_tick && sec_cnt_q == 16'(READY_SEC - 1)) state_d = StPlay;
            StPlay:     if (sec_tick && tl_q == 7'd1) state_d = StTimesUp;
            StTimesUp:  if (sec_tick && sec_cnt_q == 16'(TIMES_UP_SEC - 1)) state_d = StLeader;
            StLeader: begin
               if (start_pend_q || (sec_tick && sec_cnt_q == 16'(LEADER_SEC - 1))) begin
                  state_d = StLogo;
               end
            end
            default:    state_d = StLogo;
         endcase
      end
   end

   always_comb begin
      sec_cnt_d    = sec_cnt_q;
      start_pend_d = start_pend_q;
      two_d        = two_player_mode;
      tl_d         = tl_q;
      if (state_chg) begin
         sec_cnt_d    = '0;
         start_pend_d = 1'b0;
      end else begin
         if (sec_tick) sec_cnt_d = sec_cnt_q + 16'd1;
         // Presses are only remembered where they can act.
         if (start_edge && (state_q == StLogo || state_q == StLeader)) start_pend_d = 1'b1;
      end
      if (state_q == StLogo && state_d == StGetReady) two_d = two_player_sel;
      if (state_d != StPlay) begin
         tl_d = '0;
      end else if (state_q != StPlay) begin
         tl_d = 7'(PLAY_SEC);
      end else if (sec_tick && tl_q != '0) begin
         tl_d = tl_q - 7'd1;
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q         <= StLogo;
         start_q         <= 1'b0;
         start_pend_q    <= 1'b0;
         sec_cnt_q       <= '0;
         tl_q            <= '0;
         two_player_mode <= 1'b0;
         logo            <= 1'b1;
         get_ready       <= 1'b0;
         play            <= 1'b0;
         times_up        <= 1'b0;
         leaderboard     <= 1'b0;
      end else begin
         state_q         <= state_d;
         start_q         <= start_btn;
         start_pend_q    <= start_pend_d;
         sec_cnt_q       <= sec_cnt_d;
         tl_q            <= tl_d;
         two_player_mode <= two_d;
         logo            <= (state_d == StLogo);
         get_ready       <= (state_d == StGetReady);
         play            <= (state_d == StPlay);
         times_up        <= (state_d == StTimesUp);
         leaderboard     <= (state_d == StLeader);
      end
   end

`ifdef GAME_SCREEN_POWERUP_EN
   logic [3:0]  lfsr_q, lfsr_d;
   logic [15:0] pu_cnt_q, pu_cnt_d;
   logic [15:0] pu_left_q, pu_left_d;
   logic [3:0]  pu_q, pu_d;
   logic        in_play, launch;

   // A launch on the exiting sec_tick is dropped because in_play is already false.
   assign in_play = (state_q == StPlay) && (state_d == StPlay);
   assign launch  = in_play && sec_tick && (pu_cnt_q == 16'(PU_PERIOD_SEC - 1));

   always_comb begin
      lfsr_d    = frame_tick ? lfsr_next(lfsr_q) : lfsr_q;
      pu_cnt_d  = pu_cnt_q;
      pu_left_d = pu_left_q;
      pu_d      = pu_q;
      if (!in_play) begin
         pu_cnt_d  = '0;
         pu_left_d = '0;
         pu_d      = '0;
      end else if (sec_tick) begin
         pu_cnt_d = launch ? '0 : pu_cnt_q + 16'd1;
         if (launch) begin
            pu_d      = pu_onehot(lfsr_q[1:0], two_player_mode);
            pu_left_d = 16'(PU_DURATION_SEC);
         end else if (pu_left_q != '0) begin
            pu_left_d = pu_left_q - 16'd1;
            if (pu_left_q == 16'd1) pu_d = '0;
         end
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         lfsr_q    <= LfsrSeed;
         pu_cnt_q  <= '0;
         pu_left_q <= '0;
         pu_q      <= '0;
      end else begin
         lfsr_q    <= lfsr_d;
         pu_cnt_q  <= pu_cnt_d;
         pu_left_q <= pu_left_d;
         pu_q      <= pu_d;
      end
   end

   assign snitch_powerup      = pu_q[PuSnitch];
   assign time_turner_powerup = pu_q[PuTimeTurner];
   assign lightning_powerup   = pu_q[PuLightning];
   assign broom_powerup       = pu_q[PuBroom];
`else
   assign snitch_powerup      = 1'b0;
   assign time_turner_powerup = 1'b0;
   assign lightning_powerup   = 1'b0;
   assign broom_powerup       = 1'b0;
`endif

endmodule
